mem_access_unit: RTL and testbench

- Load/store sequencer between the pipeline's MEM stage and the byte-addressed, big-endian data memory.
- The memory has combinational word reads and clocked whole-word writes only.
- This block turns byte, halfword and word requests (signed and unsigned loads; stores) into aligned word accesses, using read-modify-write for sub-word stores.
- It checks alignment and address range before touching memory, and returns results over a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a big-endian, word-wide data
// memory. Turns byte/half/word requests into aligned word accesses and uses
// read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request; checks alignment and range on accept
// READ  | memory word addressed; captured at the closing edge
// WRITE | single-cycle write of the final word (mem_en high)
// RESP  | response held until the consumer takes it
module mem_access_unit #(
  parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
  parameter logic [31:0] MEM_DEPTH = 32'd250000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_rw,
  output logic        mem_en
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_en_q, mem_en_d;
  // Only the byte-lane bits and the low half of store data are needed after
  // accept; the word address itself lives in mem_addr_q.
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_lo_q, wdata_lo_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;

  logic [31:0] req_off, req_last;
  logic        req_misaligned, req_out_of_range, req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val, merge_val;

  // Request legality: alignment, size encoding and the last byte of the
  // containing word must fall inside the memory.
  always_comb begin
    req_off          = req_addr - MEM_BASE;
    req_last         = {req_off[31:2], 2'b00} + 32'd3;
    req_misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    req_out_of_range = (req_addr < MEM_BASE) || (req_last > MEM_DEPTH);
    req_err          = req_misaligned || (req_size == 2'b11) || req_out_of_range;
  end

  // Big-endian lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    case (addr_lo_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = addr_lo_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    if (size_q == 2'b00)      load_val = {{24{rd_byte[7] & ~unsigned_q}}, rd_byte};
    else if (size_q == 2'b01) load_val = {{16{rd_half[15] & ~unsigned_q}}, rd_half};
    else                      load_val = mem_rdata;

    merge_val = mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_lo_q)
        2'd0:    merge_val[31:24] = wdata_lo_q[7:0];
        2'd1:    merge_val[23:16] = wdata_lo_q[7:0];
        2'd2:    merge_val[15:8]  = wdata_lo_q[7:0];
        default: merge_val[7:0]   = wdata_lo_q[7:0];
      endcase
    end else if (addr_lo_q[1]) begin
      merge_val[15:0] = wdata_lo_q;
    end else begin
      merge_val[31:16] = wdata_lo_q;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rw_d     = mem_rw_q;
    mem_en_d     = mem_en_q;
    addr_lo_d    = addr_lo_q;
    wdata_lo_d   = wdata_lo_q;
    store_d      = store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d   = req_addr[1:0];
          wdata_lo_d  = req_wdata[15:0];
          store_d     = req_store;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_store || (req_size != 2'b10)) begin
            state_d    = READ;
            mem_addr_d = {req_addr[31:2], 2'b00};
            mem_rw_d   = 1'b1;
          end else begin
            state_d     = WRITE;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_rw_d    = 1'b0;
            mem_en_d    = 1'b1;
          end
        end
      end
      READ: begin
        if (!store_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = load_val;
        end else begin
          state_d     = WRITE;
          mem_wdata_d = merge_val;
          mem_rw_d    = 1'b0;
          mem_en_d    = 1'b1;
        end
      end
      WRITE: begin
        state_d      = RESP;
        mem_en_d     = 1'b0;
        mem_rw_d     = 1'b1;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
      end
      default: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops mem_en immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_rw_q     <= 1'b1;
      mem_en_q     <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_lo_q   <= 16'h0;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rw_q     <= mem_rw_d;
      mem_en_q     <= mem_en_d;
      addr_lo_q    <= addr_lo_d;
      wdata_lo_q   <= wdata_lo_d;
      store_q      <= store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;
  assign mem_en     = mem_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rw;
  logic        mem_en;

  int vectors = 0;
  int miscompares = 0;

  // Memory model: 64 words, indexed by address bits [7:2].
  logic [31:0] mem [0:63];
  logic        bk_we;
  logic [5:0]  bk_idx;
  logic [31:0] bk_data;
  int          en_count = 0;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  mem_access_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rw       (mem_rw),
    .mem_en       (mem_en)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clock) begin
    if (bk_we) mem[bk_idx] <= bk_data;
    else if (mem_en && !mem_rw) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en) begin
      en_count   <= en_count + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clock);
    bk_we = 1'b1; bk_idx = idx; bk_data = data;
    @(posedge clock); #1;
    bk_we = 1'b0;
  endtask

  // Presents one request, returns the number of edges from the accept edge
  // until resp_valid is seen (20 means it never came).
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic st,
                       input logic [1:0] sz, input logic un, output int lat);
    @(negedge clock);
    req_addr = a; req_wdata = wd; req_store = st; req_size = sz; req_unsigned = un;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #3;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    vectors++; if (mem_rw !== 1'b1) begin miscompares++; $display("FAIL reset_mem_rw: got %b want 1", mem_rw); end
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
  endtask

  task automatic test_load_word();
    int lat;
    issue(32'h8002_0004, 32'h0, 1'b0, 2'b10, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lw_latency: got %0d want 2", lat); end
    vectors++; if (resp_rdata !== 32'h1122_3344) begin miscompares++; $display("FAIL lw_rdata: got %h want 11223344", resp_rdata); end
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL lw_error: got %b want 0", resp_error); end
    finish_resp();
  endtask

  task automatic test_sub_loads();
    logic [31:0] t_addr [8];
    logic [1:0]  t_size [8];
    logic        t_uns  [8];
    logic [31:0] t_exp  [8];
    int lat;
    t_addr[0] = 32'h8002_00A0; t_size[0] = 2'b00; t_uns[0] = 1'b0; t_exp[0] = 32'hFFFF_FFAA;
    t_addr[1] = 32'h8002_00A0; t_size[1] = 2'b00; t_uns[1] = 1'b1; t_exp[1] = 32'h0000_00AA;
    t_addr[2] = 32'h8002_00A2; t_size[2] = 2'b01; t_uns[2] = 1'b0; t_exp[2] = 32'hFFFF_CCDD;
    t_addr[3] = 32'h8002_00A2; t_size[3] = 2'b01; t_uns[3] = 1'b1; t_exp[3] = 32'h0000_CCDD;
    t_addr[4] = 32'h8002_00A3; t_size[4] = 2'b00; t_uns[4] = 1'b0; t_exp[4] = 32'hFFFF_FFDD;
    t_addr[5] = 32'h8002_00A1; t_size[5] = 2'b00; t_uns[5] = 1'b1; t_exp[5] = 32'h0000_00BB;
    t_addr[6] = 32'h8002_00A0; t_size[6] = 2'b01; t_uns[6] = 1'b0; t_exp[6] = 32'hFFFF_AABB;
    t_addr[7] = 32'h8002_0005; t_size[7] = 2'b00; t_uns[7] = 1'b0; t_exp[7] = 32'h0000_0022;
    for (int i = 0; i < 8; i++) begin
      issue(t_addr[i], 32'h0, 1'b0, t_size[i], t_uns[i], lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL subload%0d_latency: got %0d want 2", i, lat); end
      vectors++; if (resp_rdata !== t_exp[i]) begin miscompares++; $display("FAIL subload%0d_rdata: got %h want %h", i, resp_rdata, t_exp[i]); end
      finish_resp();
    end
  endtask

  task automatic test_store_byte();
    int lat;
    int en0;
    en0 = en_count;
    issue(32'h8002_0006, 32'h0000_00EE, 1'b1, 2'b00, 1'b0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sb_latency: got %0d want 3", lat); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL sb_rdata: got %h want 0", resp_rdata); end
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL sb_error: got %b want 0", resp_error); end
    vectors++; if (en_count - en0 !== 1) begin miscompares++; $display("FAIL sb_write_count: got %0d want 1", en_count - en0); end
    vectors++; if (last_waddr !== 32'h8002_0004) begin miscompares++; $display("FAIL sb_waddr: got %h want 80020004", last_waddr); end
    vectors++; if (mem[1] !== 32'h1122_EE44) begin miscompares++; $display("FAIL sb_mem: got %h want 1122ee44", mem[1]); end
    finish_resp();
  endtask

  task automatic test_store_word_half();
    int lat;
    int en0;
    en0 = en_count;
    issue(32'h8002_0008, 32'h5A5A_0F0F, 1'b1, 2'b10, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d want 2", lat); end
    vectors++; if (en_count - en0 !== 1) begin miscompares++; $display("FAIL sw_write_count: got %0d want 1", en_count - en0); end
    vectors++; if (mem[2] !== 32'h5A5A_0F0F) begin miscompares++; $display("FAIL sw_mem: got %h want 5a5a0f0f", mem[2]); end
    finish_resp();
    en0 = en_count;
    issue(32'h8002_0006, 32'hFFFF_BEEF, 1'b1, 2'b01, 1'b0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sh_latency: got %0d want 3", lat); end
    vectors++; if (last_wdata !== 32'h1122_BEEF) begin miscompares++; $display("FAIL sh_wdata: got %h want 1122beef", last_wdata); end
    vectors++; if (en_count - en0 !== 1) begin miscompares++; $display("FAIL sh_write_count: got %0d want 1", en_count - en0); end
    finish_resp();
  endtask

  task automatic test_errors();
    logic [31:0] t_addr [6];
    logic [1:0]  t_size [6];
    logic        t_st   [6];
    int lat;
    int en0;
    t_addr[0] = 32'h8002_0001; t_size[0] = 2'b01; t_st[0] = 1'b1;
    t_addr[1] = 32'h8000_0000; t_size[1] = 2'b10; t_st[1] = 1'b0;
    t_addr[2] = 32'h8005_D090; t_size[2] = 2'b10; t_st[2] = 1'b0;
    t_addr[3] = 32'h8002_0002; t_size[3] = 2'b10; t_st[3] = 1'b0;
    t_addr[4] = 32'h8002_0004; t_size[4] = 2'b11; t_st[4] = 1'b0;
    t_addr[5] = 32'h8001_FFFF; t_size[5] = 2'b00; t_st[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en0 = en_count;
      issue(t_addr[i], 32'hDEAD_BEEF, t_st[i], t_size[i], 1'b0, lat);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
      vectors++; if (resp_error !== 1'b1) begin miscompares++; $display("FAIL err%0d_error: got %b want 1", i, resp_error); end
      vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL err%0d_rdata: got %h want 0", i, resp_rdata); end
      finish_resp();
      vectors++; if (en_count !== en0) begin miscompares++; $display("FAIL err%0d_mem_en: got %0d enables want 0", i, en_count - en0); end
    end
  endtask

  task automatic test_range_edge();
    int lat;
    issue(32'h8005_D08C, 32'h0, 1'b0, 2'b10, 1'b0, lat);
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL edge_lw_error: got %b want 0", resp_error); end
    vectors++; if (resp_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL edge_lw_rdata: got %h want cafef00d", resp_rdata); end
    finish_resp();
    issue(32'h8005_D08F, 32'h0, 1'b0, 2'b00, 1'b0, lat);
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL edge_lb_error: got %b want 0", resp_error); end
    vectors++; if (resp_rdata !== 32'h0000_000D) begin miscompares++; $display("FAIL edge_lb_rdata: got %h want 0000000d", resp_rdata); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    issue(32'h8002_00A0, 32'h0, 1'b0, 2'b00, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp%0d_valid: got %b want 1", c, resp_valid); end
      vectors++; if (resp_rdata !== 32'hFFFF_FFAA) begin miscompares++; $display("FAIL bp%0d_rdata: got %h want ffffffaa", c, resp_rdata); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_req_ready: got %b want 0", c, req_ready); end
    end
    finish_resp();
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", resp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_reset_during_write();
    int lat;
    int en0;
    en0 = en_count;
    @(negedge clock);
    req_addr = 32'h8002_00A0; req_wdata = 32'h0000_1234; req_store = 1'b1;
    req_size = 2'b01; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL rst_write_entered: got mem_en %b want 1", mem_en); end
    reset_n = 1'b0;
    #1;
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++; if (mem[40] !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL rst_mem_word: got %h want aabbccdd", mem[40]); end
    vectors++; if (en_count !== en0) begin miscompares++; $display("FAIL rst_write_count: got %0d want 0", en_count - en0); end
    issue(32'h8002_00A0, 32'h0, 1'b0, 2'b10, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rst_after_latency: got %0d want 2", lat); end
    vectors++; if (resp_rdata !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL rst_after_rdata: got %h want aabbccdd", resp_rdata); end
    finish_resp();
  endtask

  initial begin
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_store = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b1;
    bk_we = 1'b0; bk_idx = 6'd0; bk_data = 32'h0;
    test_reset();
    preload(6'd1, 32'h1122_3344);
    preload(6'd40, 32'hAABB_CCDD);
    preload(6'd35, 32'hCAFE_F00D);
    test_load_word();
    test_sub_loads();
    test_store_byte();
    test_store_word_half();
    test_errors();
    test_range_edge();
    test_backpressure();
    test_reset_during_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
